kl_arbiter_nby1: RTL and testbench
==================================

Name: kl_arbiter_nby1

Overview:
Parametrised KLink request/response arbiter joining N_UP uplink masters to one downlink port. It is the generalised successor of the fixed 2-port arbiter.
- Request channel: round-robin grant among valid uplinks. The grant is locked for the full length of multi-beat write bursts.
- Response channel: beats are routed by dn_resp_dstid, and the route is locked for the full length of multi-beat read bursts.
- Unknown destinations are drained and flagged.
- Sits between L1 caches/uncached ports and the memory-side KLink fabric.

Parameters:
- N_UP, 4, number of uplink ports (2..8).
- SRC_ID_BASE, 5'd0, srcid of uplink i is SRC_ID_BASE+i; SRC_ID_BASE+N_UP-1 must be at most 31.
- MAX_BURST_WIDTH, 4, maximum burst of 2^MAX_BURST_WIDTH beats.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset.
- up_req_addr  in  48*N_UP  flattened; slice i = uplink i.
- up_req_wen  in  N_UP  write enable per uplink.
- up_req_wdata  in  64*N_UP  write data per uplink.
- up_req_wmask  in  8*N_UP  byte mask per uplink.
- up_req_size  in  3*N_UP  log2 bytes per uplink.
- up_req_valid  in  N_UP  request valid per uplink.
- up_req_ready  out  N_UP  request ready per uplink.
- up_resp_rdata  out  64*N_UP  response data per uplink.
- up_resp_valid  out  N_UP  response valid per uplink.
- up_resp_ready  in  N_UP  response ready per uplink.
- dn_req_addr  out  48  downlink request address.
- dn_req_wen  out  1  downlink write enable.
- dn_req_wdata  out  64  downlink write data.
- dn_req_wmask  out  8  downlink byte mask.
- dn_req_size  out  3  downlink size.
- dn_req_srcid  out  5  srcid of the granted uplink.
- dn_req_valid  out  1  downlink request valid.
- dn_req_ready  in  1  downlink request ready.
- dn_resp_rdata  in  64  downlink response data.
- dn_resp_size  in  3  downlink response size.
- dn_resp_dstid  in  5  destination id of the response.
- dn_resp_valid  in  1  downlink response valid.
- dn_resp_ready  out  1  downlink response ready.
- err_dstid  out  1  sticky flag: a response beat arrived with an unmapped dstid.

Behaviour:
Reset and clocking:
- One clock, clk. Reset rstn is asynchronous and active-low.
- On reset: request state IDLE, response state IDLE, rr pointer = N_UP-1, all beat counters 0, err_dstid=0.
- Outputs during reset: dn_req_valid=0, dn_resp_ready=0, up_req_ready=0, up_resp_valid=0. Data outputs are don't-care but driven 0.

Beat count:
- beats(size) = 1 if size<=3, else 2^(size-3), saturated at 2^MAX_BURST_WIDTH.
- Counters are MAX_BURST_WIDTH+1 bits wide.

Request state machine, IDLE / BURST:
- IDLE, grant selection: combinational round-robin over up_req_valid. Search starts at index rr+1 and wraps modulo N_UP.
- IDLE, pass-through: the selected uplink is passed to dn_req_* with zero added latency. dn_req_srcid = SRC_ID_BASE+g.
- IDLE, readiness: up_req_ready[g] = dn_req_ready. All other up_req_ready bits are 0.
- IDLE, lock: if dn_req_valid && !dn_req_ready, register the grant (conn=g) so the selection cannot change while stalled. KLink requires valid to be held until the handshake.
- IDLE, handshake: on a handshake, rr<=g.
  - If wen && beats(size)>1: cnt<=beats-1, conn<=g, go to BURST.
  - Otherwise: stay IDLE with conn released.
- BURST: only conn is passed through. Every handshake decrements cnt. The handshake at cnt==1 releases conn and returns to IDLE.
- BURST, size field: the size on later beats is ignored.
- Grant rules: no other uplink is granted mid-burst. No request is visible downstream while none is valid.
- Single requester: it is re-granted back-to-back with no bubble cycle.

Response state machine, IDLE / BURST:
- Destination index: d = dstid - SRC_ID_BASE. It is valid iff dstid >= SRC_ID_BASE and d < N_UP.
- IDLE, routing (combinational on dn_resp_valid):
  - Valid d: up_resp_valid[d] = dn_resp_valid, up_resp_rdata[d] = dn_resp_rdata, dn_resp_ready = up_resp_ready[d].
  - Invalid d: dn_resp_ready=1, the beat is discarded, and err_dstid is set (sticky until reset).
- IDLE, handshake: if beats(dn_resp_size)>1, latch rconn=d (or DROP), set rcnt=beats-1, and go to BURST.
- BURST: routing uses rconn; dstid and size on later beats are ignored. Decrement on each handshake; the handshake at rcnt==1 returns to IDLE.
- Channel independence: request and response channels are fully independent. A response to uplink i may complete while uplink i holds the request grant.
- Reset mid-burst: both state machines abort to IDLE immediately, with no partial-beat bookkeeping retained.

Test Plan:
- N_UP=4, uplinks 0..3 each issue one size=3 read simultaneously, dn_req_ready=1 -> grants in cycles 0,1,2,3 in order 0,1,2,3. dn_req_srcid = 0,1,2,3. No idle cycle between grants.
- Uplink 1 issues a size=5 write (4 beats) while uplink 2 is valid, dn_req_ready toggled 1,0,1,1,0,1 -> 4 beats all from uplink 1; uplink 2 is granted on the cycle after the 4th handshake.
- Uplink 0 valid, dn_req_ready=0 for 5 cycles, then uplink 3 asserts valid -> dn_req_srcid stays 0 until the handshake; then rr moves on and uplink 3 is granted next.
- Response dstid=2, size=6 (8 beats), with dstid changed to 0 after beat 1 and up_resp_ready[2] stalled 3 cycles -> all 8 beats are delivered to uplink 2 and up_resp_valid[0] stays 0.
- Response dstid=9 with SRC_ID_BASE=0, N_UP=4, size=4 -> 2 beats consumed with dn_resp_ready=1, no up_resp_valid asserted, err_dstid=1 until rstn is low.
- Assert rstn=0 mid-write-burst at beat 2 of 8 -> all valid/ready outputs 0 asynchronously. After release, a new size=3 request from uplink 0 is granted in the first cycle.

Source files
------------

// File: rtl/kl_arbiter_nby1.sv
// kl_arbiter_nby1 -- KLink N-to-1 request/response arbiter.
//
// Joins N_UP uplink masters (L1 caches, uncached ports) onto a single
// memory-side KLink downlink.
//   Request channel : round-robin grant among valid uplinks; the grant is held
//                     for every beat of a multi-beat write burst and while a
//                     presented request is stalled by dn_req_ready.
//   Response channel: beats are steered to the uplink named by dn_resp_dstid;
//                     the route is held for every beat of a multi-beat read
//                     burst. Beats for unmapped ids are drained and flagged.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   up_req_*   [N_UP slices]   uplink requests (valid/ready handshake)
//   up_resp_*  [N_UP slices]   uplink responses (valid/ready handshake)
//   dn_req_*                   downlink request, srcid = SRC_ID_BASE + grant
//   dn_resp_*                  downlink response, routed by dstid
//   err_dstid                  sticky: a response beat had an unmapped dstid
module kl_arbiter_nby1 #(
  parameter int         N_UP            = 4,
  parameter logic [4:0] SRC_ID_BASE     = 5'd0,
  parameter int         MAX_BURST_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [48*N_UP-1:0]  up_req_addr,
  input  logic [N_UP-1:0]     up_req_wen,
  input  logic [64*N_UP-1:0]  up_req_wdata,
  input  logic [8*N_UP-1:0]   up_req_wmask,
  input  logic [3*N_UP-1:0]   up_req_size,
  input  logic [N_UP-1:0]     up_req_valid,
  output logic [N_UP-1:0]     up_req_ready,
  output logic [64*N_UP-1:0]  up_resp_rdata,
  output logic [N_UP-1:0]     up_resp_valid,
  input  logic [N_UP-1:0]     up_resp_ready,
  output logic [47:0]         dn_req_addr,
  output logic                dn_req_wen,
  output logic [63:0]         dn_req_wdata,
  output logic [7:0]          dn_req_wmask,
  output logic [2:0]          dn_req_size,
  output logic [4:0]          dn_req_srcid,
  output logic                dn_req_valid,
  input  logic                dn_req_ready,
  input  logic [63:0]         dn_resp_rdata,
  input  logic [2:0]          dn_resp_size,
  input  logic [4:0]          dn_resp_dstid,
  input  logic                dn_resp_valid,
  output logic                dn_resp_ready,
  output logic                err_dstid
);

  localparam int IW = (N_UP > 1) ? $clog2(N_UP) : 1;
  localparam int CW = MAX_BURST_WIDTH + 1;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  // Beats in a transfer of 2^size bytes on a 64-bit bus, capped at the
  // largest burst the counters are sized for.
  function automatic logic [CW-1:0] beats(input logic [2:0] size);
    int unsigned n;
    int unsigned n_max;
    n_max = 32'd1 << MAX_BURST_WIDTH;
    if (size <= 3'd3) n = 32'd1;
    else              n = 32'd1 << (size - 3'd3);
    if (n > n_max) n = n_max;
    return n[CW-1:0];
  endfunction

  // ---------------- request channel ----------------
  state_e           req_state_q, req_state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    conn_q, conn_d;
  logic             lock_q, lock_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [IW-1:0]    sel;
  logic             found;
  logic [IW-1:0]    g;
  logic             req_vld;
  logic             req_hs;
  logic [CW-1:0]    g_beats;

  // Round-robin search starting just after the last granted uplink; the last
  // grantee itself is tried last, so a lone requester is re-granted at once.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_UP; k++) begin
      if (!found && up_req_valid[(int'(rr_q) + k) % N_UP]) begin
        found = 1'b1;
        sel   = IW'((int'(rr_q) + k) % N_UP);
      end
    end
  end

  always_comb begin
    req_state_d = req_state_q;
    rr_d        = rr_q;
    conn_d      = conn_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    g           = sel;
    req_vld     = found;
    // A held connection (burst, or a stalled request) overrides arbitration.
    if (req_state_q == S_BURST || lock_q) begin
      g       = conn_q;
      req_vld = up_req_valid[conn_q];
    end
    req_hs  = req_vld && dn_req_ready;
    g_beats = beats(up_req_size[int'(g)*3 +: 3]);
    case (req_state_q)
      S_IDLE: begin
        if (req_hs) begin
          rr_d   = g;
          lock_d = 1'b0;
          if (up_req_wen[g] && g_beats > CW'(1)) begin
            cnt_d       = g_beats - CW'(1);
            conn_d      = g;
            req_state_d = S_BURST;
          end
        end else if (req_vld) begin
          lock_d = 1'b1;
          conn_d = g;
        end
      end
      S_BURST: begin
        if (req_hs) begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) req_state_d = S_IDLE;
        end
      end
      default: req_state_d = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    up_req_ready = '0;
    dn_req_valid = 1'b0;
    dn_req_addr  = '0;
    dn_req_wen   = 1'b0;
    dn_req_wdata = '0;
    dn_req_wmask = '0;
    dn_req_size  = '0;
    dn_req_srcid = '0;
    if (rstn && req_vld) begin
      up_req_ready[g] = dn_req_ready;
      dn_req_valid    = 1'b1;
      dn_req_addr     = up_req_addr[int'(g)*48 +: 48];
      dn_req_wen      = up_req_wen[g];
      dn_req_wdata    = up_req_wdata[int'(g)*64 +: 64];
      dn_req_wmask    = up_req_wmask[int'(g)*8 +: 8];
      dn_req_size     = up_req_size[int'(g)*3 +: 3];
      dn_req_srcid    = SRC_ID_BASE + 5'(g);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_state_q <= S_IDLE;
      rr_q        <= IW'(N_UP - 1);
      conn_q      <= '0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      req_state_q <= req_state_d;
      rr_q        <= rr_d;
      conn_q      <= conn_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
    end
  end

  // ---------------- response channel ----------------
  state_e           rsp_state_q, rsp_state_d;
  logic [IW-1:0]    rconn_q, rconn_d;
  logic             rdrop_q, rdrop_d;
  logic [CW-1:0]    rcnt_q, rcnt_d;
  logic             err_q, err_d;

  logic [4:0]       doff;
  logic             d_ok;
  logic [IW-1:0]    rsp_idx;
  logic             rsp_drop;
  logic             rsp_hs;
  logic [CW-1:0]    r_beats;

  always_comb begin
    doff     = dn_resp_dstid - SRC_ID_BASE;
    d_ok     = (dn_resp_dstid >= SRC_ID_BASE) && (int'(doff) < N_UP);
    rsp_idx  = doff[IW-1:0];
    rsp_drop = !d_ok;
    // Mid-burst, dstid/size on the bus are ignored in favour of the latched route.
    if (rsp_state_q == S_BURST) begin
      rsp_idx  = rconn_q;
      rsp_drop = rdrop_q;
    end
  end

  always_comb begin
    up_resp_valid = '0;
    up_resp_rdata = '0;
    dn_resp_ready = 1'b0;
    if (rstn) begin
      if (rsp_drop) begin
        dn_resp_ready = 1'b1;
      end else begin
        dn_resp_ready                        = up_resp_ready[rsp_idx];
        up_resp_valid[rsp_idx]               = dn_resp_valid;
        up_resp_rdata[int'(rsp_idx)*64 +: 64] = dn_resp_rdata;
      end
    end
  end

  always_comb begin
    rsp_state_d = rsp_state_q;
    rconn_d     = rconn_q;
    rdrop_d     = rdrop_q;
    rcnt_d      = rcnt_q;
    rsp_hs      = dn_resp_valid && dn_resp_ready;
    err_d       = err_q | (rsp_hs && rsp_drop);
    r_beats     = beats(dn_resp_size);
    case (rsp_state_q)
      S_IDLE: begin
        if (rsp_hs && r_beats > CW'(1)) begin
          rconn_d     = rsp_idx;
          rdrop_d     = rsp_drop;
          rcnt_d      = r_beats - CW'(1);
          rsp_state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (rsp_hs) begin
          rcnt_d = rcnt_q - CW'(1);
          if (rcnt_q == CW'(1)) rsp_state_d = S_IDLE;
        end
      end
      default: rsp_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_state_q <= S_IDLE;
      rconn_q     <= '0;
      rdrop_q     <= 1'b0;
      rcnt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rconn_q     <= rconn_d;
      rdrop_q     <= rdrop_d;
      rcnt_q      <= rcnt_d;
      err_q       <= err_d;
    end
  end

  assign err_dstid = err_q;

endmodule

// File: tb/tb_kl_arbiter_nby1.sv
module tb_kl_arbiter_nby1;

  localparam int N = 4;

  logic              clk;
  logic              rstn;
  logic [48*N-1:0]   up_req_addr;
  logic [N-1:0]      up_req_wen;
  logic [64*N-1:0]   up_req_wdata;
  logic [8*N-1:0]    up_req_wmask;
  logic [3*N-1:0]    up_req_size;
  logic [N-1:0]      up_req_valid;
  logic [N-1:0]      up_req_ready;
  logic [64*N-1:0]   up_resp_rdata;
  logic [N-1:0]      up_resp_valid;
  logic [N-1:0]      up_resp_ready;
  logic [47:0]       dn_req_addr;
  logic              dn_req_wen;
  logic [63:0]       dn_req_wdata;
  logic [7:0]        dn_req_wmask;
  logic [2:0]        dn_req_size;
  logic [4:0]        dn_req_srcid;
  logic              dn_req_valid;
  logic              dn_req_ready;
  logic [63:0]       dn_resp_rdata;
  logic [2:0]        dn_resp_size;
  logic [4:0]        dn_resp_dstid;
  logic              dn_resp_valid;
  logic              dn_resp_ready;
  logic              err_dstid;

  kl_arbiter_nby1 #(.N_UP(N), .SRC_ID_BASE(5'd0), .MAX_BURST_WIDTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .up_req_addr(up_req_addr), .up_req_wen(up_req_wen), .up_req_wdata(up_req_wdata),
    .up_req_wmask(up_req_wmask), .up_req_size(up_req_size), .up_req_valid(up_req_valid),
    .up_req_ready(up_req_ready), .up_resp_rdata(up_resp_rdata), .up_resp_valid(up_resp_valid),
    .up_resp_ready(up_resp_ready), .dn_req_addr(dn_req_addr), .dn_req_wen(dn_req_wen),
    .dn_req_wdata(dn_req_wdata), .dn_req_wmask(dn_req_wmask), .dn_req_size(dn_req_size),
    .dn_req_srcid(dn_req_srcid), .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready),
    .dn_resp_rdata(dn_resp_rdata), .dn_resp_size(dn_resp_size), .dn_resp_dstid(dn_resp_dstid),
    .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready), .err_dstid(err_dstid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  id;
    logic [47:0] addr;
    logic        wen;
  } req_t;

  typedef struct {
    int          idx;
    logic [63:0] data;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] addr_of(input int i);
    return 48'h1000 + 48'(i);
  endfunction

  task automatic push_req(input int i, input logic wen);
    req_t r;
    r.id   = 5'(i);
    r.addr = addr_of(i);
    r.wen  = wen;
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input int i, input logic [63:0] d);
    rsp_t r;
    r.idx  = i;
    r.data = d;
    exp_rsp.push_back(r);
  endtask

  // One clock: sample handshakes mid-cycle against the scoreboard, then
  // return just after the active edge so the caller can drive new inputs.
  task automatic tick();
    req_t er;
    rsp_t es;
    @(negedge clk);
    if (dn_req_valid && dn_req_ready) begin
      n_assert++;
      assert (exp_req.size() > 0) else begin
        n_fail++;
        $error("FAIL req_unexpected observed=srcid %0d expected=no handshake", dn_req_srcid);
      end
      if (exp_req.size() > 0) begin
        er = exp_req.pop_front();
        chk("req_srcid", 64'(dn_req_srcid), 64'(er.id));
        chk("req_addr",  64'(dn_req_addr),  64'(er.addr));
        chk("req_wen",   64'(dn_req_wen),   64'(er.wen));
      end
    end
    for (int i = 0; i < N; i++) begin
      if (up_resp_valid[i] && up_resp_ready[i]) begin
        n_assert++;
        assert (exp_rsp.size() > 0) else begin
          n_fail++;
          $error("FAIL rsp_unexpected observed=uplink %0d expected=no beat", i);
        end
        if (exp_rsp.size() > 0) begin
          es = exp_rsp.pop_front();
          chk("rsp_uplink", 64'(i), 64'(es.idx));
          chk("rsp_data", up_resp_rdata[i*64 +: 64], es.data);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn          = 1'b0;
    up_req_wen    = '0;
    up_req_wdata  = '0;
    up_req_wmask  = '1;
    up_req_size   = '0;
    up_req_valid  = '1;
    up_resp_ready = '1;
    dn_req_ready  = 1'b1;
    dn_resp_rdata = 64'hDEAD;
    dn_resp_size  = 3'd0;
    dn_resp_dstid = 5'd1;
    dn_resp_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      up_req_addr[i*48 +: 48] = addr_of(i);
      up_req_size[i*3 +: 3]   = 3'd3;
    end

    // Reset: every valid/ready output low despite active inputs.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dn_req_valid",  64'(dn_req_valid),  64'd0);
    chk("rst_up_req_ready",  64'(up_req_ready),  64'd0);
    chk("rst_dn_resp_ready", 64'(dn_resp_ready), 64'd0);
    chk("rst_up_resp_valid", 64'(up_resp_valid), 64'd0);
    chk("rst_dn_req_addr",   64'(dn_req_addr),   64'd0);
    chk("rst_err",           64'(err_dstid),     64'd0);
    up_req_valid  = '0;
    dn_resp_valid = 1'b0;
    rstn          = 1'b1;
    #1;
    chk("idle_no_req", 64'(dn_req_valid), 64'd0);

    // Four simultaneous single-beat reads: granted 0,1,2,3 back to back.
    up_req_valid = 4'b1111;
    for (int k = 0; k < N; k++) push_req(k, 1'b0);
    for (int k = 0; k < N; k++) begin
      #1;
      chk("t1_no_bubble", 64'(dn_req_valid), 64'd1);
      chk("t1_ready_onehot", 64'(up_req_ready), 64'(4'b0001 << k));
      tick();
      up_req_valid[k] = 1'b0;
    end
    chk("t1_sb_drained", 64'(exp_req.size()), 64'd0);

    // 4-beat write from uplink 1 with uplink 2 waiting; ready toggles.
    up_req_wen[1]        = 1'b1;
    up_req_size[1*3 +: 3] = 3'd5;
    up_req_valid         = 4'b0110;
    for (int k = 0; k < 4; k++) push_req(1, 1'b1);
    push_req(2, 1'b0);
    begin
      logic [5:0] rdy_pat;
      rdy_pat = 6'b101101;
      for (int k = 0; k < 6; k++) begin
        dn_req_ready = rdy_pat[k];
        #1;
        chk("t2_burst_srcid", 64'(dn_req_srcid), 64'd1);
        chk("t2_up2_not_ready", 64'(up_req_ready[2]), 64'd0);
        tick();
        if (k == 0) up_req_size[1*3 +: 3] = 3'd0;
      end
    end
    up_req_valid[1] = 1'b0;
    up_req_wen[1]   = 1'b0;
    dn_req_ready    = 1'b1;
    #1;
    chk("t2_next_grant", 64'(dn_req_srcid), 64'd2);
    tick();
    up_req_valid[2] = 1'b0;
    chk("t2_sb_drained", 64'(exp_req.size()), 64'd0);

    // Stalled request from uplink 0 keeps the grant when uplink 3 shows up.
    up_req_valid[0] = 1'b1;
    dn_req_ready    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_stall_srcid", 64'(dn_req_srcid), 64'd0);
      tick();
    end
    up_req_valid[3] = 1'b1;
    #1;
    chk("t3_locked_srcid", 64'(dn_req_srcid), 64'd0);
    tick();
    push_req(0, 1'b0);
    push_req(3, 1'b0);
    dn_req_ready = 1'b1;
    tick();
    up_req_valid[0] = 1'b0;
    tick();
    up_req_valid[3] = 1'b0;
    chk("t3_sb_drained", 64'(exp_req.size()), 64'd0);

    // 8-beat read response to uplink 2; dstid changes and uplink 2 stalls.
    dn_resp_valid = 1'b1;
    dn_resp_dstid = 5'd2;
    dn_resp_size  = 3'd6;
    dn_resp_rdata = 64'hA0;
    push_rsp(2, 64'hA0);
    #1;
    chk("t4_route_first", 64'(up_resp_valid), 64'b0100);
    tick();
    dn_resp_dstid = 5'd0;
    dn_resp_size  = 3'd0;
    dn_resp_rdata = 64'hA1;
    up_resp_ready = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_route", 64'(up_resp_valid), 64'b0100);
      chk("t4_stall_ready", 64'(dn_resp_ready), 64'd0);
      tick();
    end
    up_resp_ready = 4'b1111;
    for (int b = 1; b < 8; b++) begin
      dn_resp_rdata = 64'hA0 + 64'(b);
      push_rsp(2, dn_resp_rdata);
      #1;
      chk("t4_route_locked", 64'(up_resp_valid), 64'b0100);
      tick();
    end
    dn_resp_valid = 1'b0;
    chk("t4_sb_drained", 64'(exp_rsp.size()), 64'd0);

    // 2-beat response to unmapped dstid 9: drained and flagged.
    chk("t5_err_before", 64'(err_dstid), 64'd0);
    dn_resp_valid = 1'b1;
    dn_resp_dstid = 5'd9;
    dn_resp_size  = 3'd4;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_drain_ready", 64'(dn_resp_ready), 64'd1);
      chk("t5_no_up_valid", 64'(up_resp_valid), 64'd0);
      tick();
      dn_resp_dstid = 5'd1;
    end
    // Drop burst has ended: a single beat to uplink 3 is routed normally.
    dn_resp_dstid = 5'd3;
    dn_resp_size  = 3'd0;
    dn_resp_rdata = 64'h5A5A;
    push_rsp(3, 64'h5A5A);
    #1;
    chk("t5_err_set", 64'(err_dstid), 64'd1);
    tick();
    dn_resp_valid = 1'b0;
    tick();
    chk("t5_err_sticky", 64'(err_dstid), 64'd1);
    chk("t5_sb_drained", 64'(exp_rsp.size()), 64'd0);

    // Reset in the middle of an 8-beat write from uplink 0.
    up_req_wen[0]         = 1'b1;
    up_req_size[0*3 +: 3] = 3'd6;
    up_req_valid[0]       = 1'b1;
    dn_req_ready          = 1'b1;
    push_req(0, 1'b1);
    push_req(0, 1'b1);
    tick();
    tick();
    dn_resp_valid = 1'b1;
    dn_resp_dstid = 5'd1;
    rstn          = 1'b0;
    #1;
    chk("t6_rst_dn_req_valid",  64'(dn_req_valid),  64'd0);
    chk("t6_rst_up_req_ready",  64'(up_req_ready),  64'd0);
    chk("t6_rst_dn_resp_ready", 64'(dn_resp_ready), 64'd0);
    chk("t6_rst_up_resp_valid", 64'(up_resp_valid), 64'd0);
    chk("t6_rst_err_clear",     64'(err_dstid),     64'd0);
    dn_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    up_req_wen[0]         = 1'b0;
    up_req_size[0*3 +: 3] = 3'd3;
    rstn                  = 1'b1;
    push_req(0, 1'b0);
    #1;
    chk("t6_first_grant", 64'(dn_req_srcid), 64'd0);
    tick();
    up_req_valid[0] = 1'b0;
    up_req_valid[1] = 1'b1;
    push_req(1, 1'b0);
    #1;
    chk("t6_idle_after_rst", 64'(dn_req_valid), 64'd1);
    tick();
    up_req_valid[1] = 1'b0;
    tick();
    chk("t6_sb_drained", 64'(exp_req.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
